// File: rtl/lcd_source_sequencer.sv
// Arbitrates the single LCD write port between a one-shot initialiser (source 0)
// and round-robin refresh layers, with per-grant watchdog and frame counting.
module lcd_source_sequencer #(
  parameter int DATA_W      = 9,
  parameter int NUM_SRC     = 4,
  parameter int START_CYC   = 7,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic                      sys_clk_50MHz,
  input  logic                      sys_rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_en_write,
  input  logic [NUM_SRC-1:0]        src_done,
  input  logic [NUM_SRC-2:0]        src_enable,
  output logic [NUM_SRC-1:0]        src_start,
  output logic [DATA_W-1:0]         data,
  output logic                      en_write,
  output logic [2:0]                active_src,
  output logic                      init_ok,
  output logic                      frame_done,
  output logic [15:0]               frame_count,
  output logic                      timeout_err,
  output logic                      led
);

  localparam int          SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [3:0]  START_LAST = 4'(START_CYC);
  localparam logic [23:0] WD_LAST    = (TIMEOUT_CYC == 0) ? 24'd0 : 24'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_INIT, ST_SELECT, ST_RUN, ST_IDLE} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
    logic       wrap;
  } pick_t;

  state_t              state;
  logic [3:0]          start_cnt;
  logic [23:0]         watchdog;
  logic [2:0]          sel_src;
  logic                sel_none;
  pick_t               pick;
  logic [SRC_W-1:0]    cur;
  logic                granted;
  logic [DATA_W-1:0]   src_word [NUM_SRC];

  // First enabled refresh source strictly after origin, wrapping within 1..NUM_SRC-1.
  function automatic pick_t pick_next(input logic [2:0] origin, input logic [NUM_SRC-2:0] en);
    pick_t      p;
    logic [7:0] en_pad;
    int         cand;
    p      = '0;
    en_pad = 8'(en);
    for (int off = NUM_SRC - 1; off >= 1; off--) begin
      cand = int'(origin) + off;
      if (cand > NUM_SRC - 1) cand = cand - (NUM_SRC - 1);
      if (en_pad[3'(cand - 1)]) begin
        p.found = 1'b1;
        p.idx   = 3'(cand);
      end
    end
    p.wrap = p.found && (origin != 3'd0) && (p.idx <= origin);
    return p;
  endfunction

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_word
    assign src_word[k] = src_data[k*DATA_W +: DATA_W];
  end

  assign cur     = active_src[SRC_W-1:0];
  assign granted = (state == ST_INIT) || (state == ST_RUN);
  assign led     = !init_ok;

  always_comb pick = pick_next(active_src, src_enable);

  // NOTE: every output gets a default before the if, so no latch is inferred.
  always_comb begin
    src_start = '0;
    data      = '0;
    en_write  = 1'b0;
    if (granted) begin
      data     = src_word[cur];
      en_write = src_en_write[cur];
      if (start_cnt < START_LAST) src_start[cur] = 1'b1;
    end
  end

  // The next grant is chosen on the edge entering SELECT, so frame_done can be a
  // register that is high for exactly the SELECT cycle that decides the wrap.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state       <= ST_INIT;
      active_src  <= 3'd0;
      start_cnt   <= 4'd0;
      watchdog    <= 24'd0;
      init_ok     <= 1'b0;
      frame_count <= 16'd0;
      timeout_err <= 1'b0;
      frame_done  <= 1'b0;
      sel_src     <= 3'd0;
      sel_none    <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_INIT: begin
          if (start_cnt != START_LAST) start_cnt <= start_cnt + 4'd1;
          if (src_done[0]) begin
            init_ok    <= 1'b1;
            state      <= ST_SELECT;
            sel_src    <= pick.idx;
            sel_none   <= !pick.found;
            frame_done <= pick.wrap;
          end
        end
        ST_SELECT: begin
          if (frame_done) frame_count <= frame_count + 16'd1;
          if (sel_none) begin
            state <= ST_IDLE;
          end else begin
            state      <= ST_RUN;
            active_src <= sel_src;
            start_cnt  <= 4'd0;
            watchdog   <= 24'd0;
          end
        end
        ST_RUN: begin
          if (start_cnt != START_LAST) start_cnt <= start_cnt + 4'd1;
          if (src_done[cur]) begin
            state      <= ST_SELECT;
            sel_src    <= pick.idx;
            sel_none   <= !pick.found;
            frame_done <= pick.wrap;
          end else if ((TIMEOUT_CYC != 0) && (watchdog == WD_LAST)) begin
            timeout_err <= 1'b1;
            state       <= ST_SELECT;
            sel_src     <= pick.idx;
            sel_none    <= !pick.found;
            frame_done  <= pick.wrap;
          end else begin
            watchdog <= watchdog + 24'd1;
          end
        end
        ST_IDLE: begin
          if (|src_enable) begin
            state      <= ST_SELECT;
            sel_src    <= pick.idx;
            sel_none   <= !pick.found;
            frame_done <= pick.wrap;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_source_sequencer.sv
// Directed bench for lcd_source_sequencer: init, round-robin, masking, idle,
// watchdog abort and mid-grant reset.
module tb_lcd_source_sequencer;

  localparam int DATA_W      = 9;
  localparam int NUM_SRC     = 4;
  localparam int START_CYC   = 7;
  localparam int TIMEOUT_CYC = 50;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_en_write;
  logic [NUM_SRC-1:0]        src_done;
  logic [NUM_SRC-2:0]        src_enable;
  logic [NUM_SRC-1:0]        src_start;
  logic [DATA_W-1:0]         data;
  logic                      en_write;
  logic [2:0]                active_src;
  logic                      init_ok;
  logic                      frame_done;
  logic [15:0]               frame_count;
  logic                      timeout_err;
  logic                      led;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  lcd_source_sequencer #(
    .DATA_W      (DATA_W),
    .NUM_SRC     (NUM_SRC),
    .START_CYC   (START_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .src_data      (src_data),
    .src_en_write  (src_en_write),
    .src_done      (src_done),
    .src_enable    (src_enable),
    .src_start     (src_start),
    .data          (data),
    .en_write      (en_write),
    .active_src    (active_src),
    .init_ok       (init_ok),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .timeout_err   (timeout_err),
    .led           (led)
  );

  typedef struct {
    logic [2:0] mask;       // enable mask held during this grant
    logic [3:0] ew;         // per-source write strobes during this grant
    int         src;        // expected grant holder
    bit         exp_frame;  // frame_done expected in the SELECT before it
    int         exp_count;  // frame_count expected at grant start
  } vec_t;

  vec_t vecs [9];

  function automatic logic [DATA_W-1:0] word(input int k);
    return DATA_W'(9'h0A5 + k * 37);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a SELECT negedge; waits for the next start, checks it, runs 10 cycles, signals done.
  task automatic do_grant(input vec_t v);
    int waited;
    bit saw_frame;
    logic [3:0] ew;
    waited       = 0;
    saw_frame    = 1'b0;
    ew           = v.ew;
    src_en_write = v.ew;
    while (src_start == '0 && waited < 20) begin
      saw_frame |= frame_done;
      @(negedge clk);
      waited++;
    end
    check("sel_gap", 32'(waited), 32'd1);
    check("grant_start", 32'(src_start), 32'(1) << v.src);
    check("grant_active", 32'(active_src), 32'(v.src));
    check("grant_frame_done", 32'(saw_frame), 32'(v.exp_frame));
    check("grant_frame_count", 32'(frame_count), 32'(v.exp_count));
    check("grant_data", 32'(data), 32'(word(v.src)));
    check("grant_en_write", 32'(en_write), 32'(ew[v.src]));
    src_enable = v.mask;
    repeat (10) @(negedge clk);
    src_done[v.src] = 1'b1;
    @(negedge clk);
    src_done = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b111, 4'b1010, 1, 1'b0, 0};
    vecs[1] = '{3'b111, 4'b1010, 2, 1'b0, 0};
    vecs[2] = '{3'b111, 4'b1010, 3, 1'b0, 0};
    vecs[3] = '{3'b111, 4'b1010, 1, 1'b1, 1};
    vecs[4] = '{3'b111, 4'b1010, 2, 1'b0, 1};
    vecs[5] = '{3'b101, 4'b1010, 3, 1'b0, 1};
    vecs[6] = '{3'b101, 4'b0100, 1, 1'b1, 2};
    vecs[7] = '{3'b101, 4'b0100, 3, 1'b0, 2};
    vecs[8] = '{3'b000, 4'b0100, 1, 1'b1, 3};

    rst          = 1'b1;
    src_done     = '0;
    src_en_write = 4'b0001;
    src_enable   = 3'b111;
    for (int k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = word(k);

    repeat (3) @(negedge clk);
    check("rst_start", 32'(src_start), 32'b0001);
    check("rst_active", 32'(active_src), 32'd0);
    check("rst_init_ok", 32'(init_ok), 32'd0);
    check("rst_led", 32'(led), 32'd1);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("init_data", 32'(data), 32'(word(0)));
    check("init_en_write", 32'(en_write), 32'd1);

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("init_start_flag", 32'(src_start), (i < START_CYC) ? 32'b0001 : 32'd0);
      check("init_led", 32'(led), 32'd1);
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    src_done[0] = 1'b1;
    @(negedge clk);
    src_done = '0;
    check("init_ok_set", 32'(init_ok), 32'd1);
    check("init_led_off", 32'(led), 32'd0);
    check("select_idle_start", 32'(src_start), 32'd0);
    check("select_idle_en", 32'(en_write), 32'd0);

    for (int i = 0; i < 9; i++) do_grant(vecs[i]);

    // No source enabled: bus parks idle even with every strobe high.
    src_en_write = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("idle_data", 32'(data), 32'd0);
      check("idle_en_write", 32'(en_write), 32'd0);
      check("idle_start", 32'(src_start), 32'd0);
      @(negedge clk);
    end
    src_enable = 3'b010;
    @(negedge clk);
    check("reenable_select", 32'(src_start), 32'd0);
    @(negedge clk);
    check("reenable_start", 32'(src_start), 32'b0100);
    check("reenable_active", 32'(active_src), 32'd2);
    check("reenable_data", 32'(data), 32'(word(2)));
    check("reenable_frame_count", 32'(frame_count), 32'd3);

    // Source 2 never completes; the watchdog must abort after TIMEOUT_CYC cycles.
    src_enable = 3'b111;
    begin
      int waited;
      waited = 0;
      while (!timeout_err && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check("wd_grant_len", 32'(waited), 32'(TIMEOUT_CYC));
    end
    check("wd_err_set", 32'(timeout_err), 32'd1);
    check("wd_select_start", 32'(src_start), 32'd0);
    @(negedge clk);
    check("wd_next_start", 32'(src_start), 32'b1000);
    check("wd_next_active", 32'(active_src), 32'd3);
    src_done[2] = 1'b1;
    repeat (5) @(negedge clk);
    check("stale_done_ignored", 32'(src_start), 32'b1000);
    check("stale_done_active", 32'(active_src), 32'd3);
    check("wd_err_sticky", 32'(timeout_err), 32'd1);
    check("pre_reset_count", 32'(frame_count), 32'd3);
    src_done = '0;

    // Reset during the source-3 grant, coinciding with its done.
    rst         = 1'b1;
    src_done[3] = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    src_done = '0;
    check("mid_rst_start", 32'(src_start), 32'b0001);
    check("mid_rst_active", 32'(active_src), 32'd0);
    check("mid_rst_count", 32'(frame_count), 32'd0);
    check("mid_rst_timeout", 32'(timeout_err), 32'd0);
    check("mid_rst_led", 32'(led), 32'd1);
    @(negedge clk);
    check("mid_rst_init_rerun", 32'(src_start), 32'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_source_sequencer.md
# lcd_source_sequencer

Parametrised successor to the LCD control coordinator. It owns the single LCD write port and grants it to one of `NUM_SRC` drawing sources at a time. Source 0 is the one-shot panel initialiser; sources 1..`NUM_SRC`-1 are refresh layers served round-robin, with runtime enable masking. The block adds a per-grant watchdog, frame counting and error reporting. It sits between the init/picture/line generators and the LCD bus driver.

## Interface
Parameters:
- `DATA_W`, 9: LCD word width (bit 8 is D/C).
- `NUM_SRC`, 4: source count, including init source 0. Legal range 2..8.
- `START_CYC`, 7: number of cycles each grant's start flag stays high. Legal range 1..15.
- `TIMEOUT_CYC`, 2^20: maximum cycles a grant may last before abort. 0 disables the watchdog. Must fit in 24 bits.

Ports:
- `sys_clk_50MHz`, in, 1: the single clock.
- `sys_rst`, in, 1: synchronous, active-high reset.
- `src_data`, in, `NUM_SRC*DATA_W`: per-source write data. Source k occupies bits [k*DATA_W +: DATA_W].
- `src_en_write`, in, `NUM_SRC`: per-source write strobe.
- `src_done`, in, `NUM_SRC`: per-source completion level or pulse.
- `src_enable`, in, `NUM_SRC-1`: enable mask for sources 1..`NUM_SRC`-1 (bit i maps to source i+1).
- `src_start`, out, `NUM_SRC`: start flag, one-hot or zero.
- `data`, out, `DATA_W`: muxed LCD data.
- `en_write`, out, 1: muxed write strobe.
- `active_src`, out, 3: index of the current grant holder.
- `init_ok`, out, 1: high once source 0 has completed.
- `frame_done`, out, 1: one-cycle pulse at the end of each round-robin pass.
- `frame_count`, out, 16: number of completed passes; wraps.
- `timeout_err`, out, 1: sticky; cleared only by reset.
- `led`, out, 1: high while uninitialised, low after init completes.

## Operation
The state machine has four states: INIT, SELECT, RUN, IDLE.
- **Reset:** state=INIT, `active_src`=0, start counter=0, watchdog=0, `init_ok`=0, `frame_count`=0, `timeout_err`=0, `frame_done`=0.
- **INIT:** source 0 holds the grant. `src_start[0]` is high for the first `START_CYC` cycles. On `src_done[0]`: set `init_ok`, go to SELECT with search origin 0.
- **SELECT (one cycle):** the bus is idle.
  - Sample `src_enable`.
  - Pick the first enabled index strictly after `active_src`, wrapping within 1..`NUM_SRC`-1. If `active_src` is the only enabled source, it is reselected.
  - If no source is enabled, go to IDLE.
  - If the chosen index ≤ the previous `active_src` and the previous `active_src` ≠ 0, pulse `frame_done` and increment `frame_count` (mod 2^16). Do the same if a single enabled source is reselected.
- **RUN:** the chosen source k holds the grant. Load `active_src`=k, clear the start counter and the watchdog. `src_start[k]` is high for the first `START_CYC` cycles.
  - `src_done[k]` → SELECT.
  - Watchdog reaching `TIMEOUT_CYC`-1 with no done → set `timeout_err`, go to SELECT. The aborted source is skipped as for a normal completion.
- **IDLE:** the bus is idle. Each cycle, if any `src_enable` bit is set → SELECT.

Mux and signal-handling rules:
- Output mux in INIT/RUN: `data`=slice of `active_src`, `en_write`=`src_en_write[active_src]`. In SELECT/IDLE both are 0.
- `src_done`/`src_en_write` from non-holders are ignored.
- A done asserted while the start flag is still high is honoured, and the start flag drops with the state change.
- Source 0 is never reselected after init.
- `src_enable` changes take effect only in SELECT. A running grant whose enable bit drops still runs to done or timeout.
- `led` = !`init_ok`.

## Timing
- All state and status are registered. `data`/`en_write`/`src_start` are combinational from registered state only; there is no combinational path from inputs except the data/strobe mux itself.
- Done sampled at edge t → SELECT during cycle t+1 → next RUN with `src_start` high from cycle t+2. Done-to-next-start latency is 2 cycles.
- `frame_done` is high during the SELECT cycle in which the wrap is decided. `frame_count` updates at the end of that cycle.
- Timeout: the grant lasts exactly `TIMEOUT_CYC` cycles, then SELECT.
- Reset asserted mid-grant: the next edge returns to INIT and init reruns. Reset dominates simultaneous done or timeout.

## Test plan
- **Reset and init:** hold reset 3 cycles, release, `src_done[0]` at cycle 20.
  - Required: `src_start`=0001 for cycles 0–6 after release; `led`=1 then 0; `init_ok`=1.
  - Required: the first source-1 start appears 2 cycles after done.
- **Round-robin, all enabled (`NUM_SRC`=4):** each source finishes 10 cycles after its start.
  - Required: grant order 1,2,3,1,2,3.
  - Required: `frame_done` pulses on 3→1; `frame_count` reads 2 after six grants.
- **Masking:** `src_enable`=101 (sources 1 and 3).
  - Required: order 1,3,1; source 2 is never granted; its `src_en_write` never reaches `en_write`.
- **All disabled then re-enable:** mask=000.
  - Required: IDLE with `data`=0 and `en_write`=0.
  - Then set mask=010: SELECT on the next cycle, source 2 started the cycle after that.
- **Watchdog (`TIMEOUT_CYC`=50):** source 2 never signals done.
  - Required: abort after 50 cycles of grant; `timeout_err`=1 and it stays set.
  - Required: the next enabled source is granted; a later done from source 2 is ignored.
- **Mid-grant reset:** reset during a source-3 grant.
  - Required: next cycle is INIT, `active_src`=0, `frame_count`=0, `src_start`=0001.
